// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cbus payload types used by the arbiter, its interface and benches.
//   cbus_req_t  : master -> slave request (valid, write flag, address, size,
//                 byte strobe, write data, burst length)
//   cbus_resp_t : slave -> master response (ready, last, read data)
// Burst length is encoded as beats-1 (MLEN1 = 0 ... MLEN16 = 15).
package cbus_rr_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } cbus_size_t;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    cbus_size_t        size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    cbus_len_t         len;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// Bus bundle around the cbus arbiter.
//   ireqs  : requests from the upstream masters (one per input)
//   iresps : responses returned to the upstream masters
//   oreq   : request forwarded to the downstream port
//   oresp  : response from the downstream port
// Modports: slave = the arbiter, master = the environment around it.
interface cbus_rr_arbiter_if
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2
);

  cbus_req_t  ireqs  [NUM_INPUTS];
  cbus_resp_t iresps [NUM_INPUTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq
  );

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq
  );

endinterface

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter from NUM_INPUTS upstream cbus masters onto one downstream
// cbus port. A grant is held for a whole transaction (single beat or burst)
// until the last beat is accepted, then priority rotates past the winner.
// The number of beats seen is checked against the request's len field.
// Ports:
//   clk     : clock
//   reset   : synchronous, active-high reset
//   bus     : cbus_rr_arbiter_if.slave (ireqs/iresps upstream, oreq/oresp downstream)
//   busy    : high while a grant is held
//   len_err : sticky, set when a last beat arrives at the wrong beat count
// Build option: define CBUS_ARB_FIXED_PRIO_EN for fixed priority (lowest
// valid index always wins); otherwise round-robin.
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2
) (
  input  logic             clk,
  input  logic             reset,
  cbus_rr_arbiter_if.slave bus,
  output logic             busy,
  output logic             len_err
);

  localparam int unsigned SEL_BITS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned SUM_W    = SEL_BITS + 1;
  localparam int unsigned LEN_W    = $bits(cbus_len_t);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state;
  logic [SEL_BITS-1:0]   sel;
  logic [SEL_BITS-1:0]   rr_ptr;
  logic [SEL_BITS-1:0]   offset;
  logic [SEL_BITS-1:0]   winner;
  logic [SEL_BITS-1:0]   next_ptr;
  logic [SUM_W-1:0]      winner_sum;
  logic [LEN_W-1:0]      beat_cnt;
  logic [NUM_INPUTS-1:0] valid_vec;
  logic [NUM_INPUTS-1:0] rotated;
  logic                  any_valid;
  cbus_req_t             cur_req;

  // Per-input valid collection and response steering.
  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_in
    assign valid_vec[g]  = bus.ireqs[g].valid;
    assign bus.iresps[g] = (state == BUSY && sel == SEL_BITS'(g)) ? bus.oresp : '0;
  end

  // Rotate the valid vector so bit 0 is the input rr_ptr points at, then take
  // the lowest set bit as the offset of the winner from rr_ptr.
  always_comb begin
    rotated = NUM_INPUTS'({valid_vec, valid_vec} >> rr_ptr);
    offset  = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (rotated[k]) offset = SEL_BITS'(k);
    end
  end

  assign any_valid  = |valid_vec;
  assign winner_sum = {1'b0, offset} + {1'b0, rr_ptr};
  assign winner     = (winner_sum >= SUM_W'(NUM_INPUTS))
                    ? SEL_BITS'(winner_sum - SUM_W'(NUM_INPUTS))
                    : SEL_BITS'(winner_sum);

  // Priority pointer after a transaction ends.
`ifdef CBUS_ARB_FIXED_PRIO_EN
  assign next_ptr = '0;
`else
  assign next_ptr = (sel == SEL_BITS'(NUM_INPUTS - 1)) ? '0 : sel + SEL_BITS'(1);
`endif

  // Selected request is passed through untouched while the grant is held.
  assign cur_req = bus.ireqs[sel];
  assign bus.oreq = (state == BUSY) ? cur_req : '0;

  // Grant FSM, beat counter and sticky length check.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            sel      <= winner;
            beat_cnt <= '0;
            state    <= BUSY;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          if (!cur_req.valid) begin
            // Master withdrew without a last beat: release, no length check.
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end else if (bus.oresp.ready) begin
            if (bus.oresp.last) begin
              state  <= IDLE;
              busy   <= 1'b0;
              rr_ptr <= next_ptr;
              if (beat_cnt != LEN_W'(cur_req.len)) len_err <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + LEN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench for cbus_rr_arbiter: a transaction-level model of the
// grant owner, priority pointer and beat count is compared against the DUT
// every cycle, alongside directed scenarios with hand-computed expectations.
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  localparam int unsigned N = 2;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic len_err;

  cbus_rr_arbiter_if #(.NUM_INPUTS(N)) bus ();

  cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_owner = -1;   // granted input, -1 when nobody holds the bus
  int  m_ptr   = 0;    // input that gets first look at the next arbitration
  int  m_beats = 0;    // beats delivered in the current transaction
  bit  m_err   = 1'b0;
  cbus_req_t  e_req;
  cbus_resp_t e_resp;

  function automatic int after(input int who);
`ifdef CBUS_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (who + 1) % N;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_err   = 1'b0;
    end else if (m_owner < 0) begin
      for (int off = 0; off < N; off++) begin
        int c;
        c = (m_ptr + off) % N;
        if (bus.ireqs[c].valid) begin
          m_owner = c;
          m_beats = 0;
          break;
        end
      end
    end else if (!bus.ireqs[m_owner].valid) begin
      m_ptr   = after(m_owner);
      m_owner = -1;
    end else if (bus.oresp.ready) begin
      m_beats++;
      if (bus.oresp.last) begin
        if (m_beats != int'(bus.ireqs[m_owner].len) + 1) m_err = 1'b1;
        m_ptr   = after(m_owner);
        m_owner = -1;
      end
    end
    #1;
    e_req = '0;
    if (m_owner >= 0) e_req = bus.ireqs[m_owner];
    check("oreq", 128'(bus.oreq), 128'(e_req));
    for (int i = 0; i < N; i++) begin
      e_resp = '0;
      if (i == m_owner) e_resp = bus.oresp;
      check($sformatf("iresps[%0d]", i), 128'(bus.iresps[i]), 128'(e_resp));
    end
    check("busy", 128'(busy), 128'(m_owner >= 0));
    check("len_err", 128'(len_err), 128'(m_err));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    for (int i = 0; i < N; i++) bus.ireqs[i] = '0;
    bus.oresp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for a grant; waits = negedges until busy was seen.
  task automatic wait_grant(output int waits);
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!busy && waits < 20);
    if (!busy) check("grant_timeout", 128'(busy), 128'(1));
  endtask

  // Drives nbeats downstream beats (last on the final one) and counts how many
  // reached the granted master.
  task automatic beats(input int idx, input int nbeats, output int seen);
    seen = 0;
    for (int k = 0; k < nbeats; k++) begin
      bus.oresp.ready = 1'b1;
      bus.oresp.last  = (k == nbeats - 1);
      bus.oresp.data  = 64'(idx * 256 + k);
      #1;
      if (bus.iresps[idx].ready) seen++;
      @(negedge clk);
    end
    bus.oresp = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    cbus_req_t r0, r1;
    int w, s, second;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_len_err", 128'(len_err), 128'(0));
    check("rst_oreq", 128'(bus.oreq), 128'(0));

    // Downstream chatter while idle must be ignored.
    bus.oresp.ready = 1'b1;
    bus.oresp.last  = 1'b1;
    repeat (2) @(negedge clk);
    bus.oresp = '0;
    check("idle_resp_busy", 128'(busy), 128'(0));
    check("idle_resp_len_err", 128'(len_err), 128'(0));

    // 1: 16-beat read on input 0.
    r0 = '0;
    r0.valid = 1'b1;
    r0.addr  = 32'h0000_1000;
    r0.size  = MSIZE8;
    r0.len   = MLEN16;
    bus.ireqs[0] = r0;
    wait_grant(w);
    check("t1_latency", 128'(w), 128'(1));
    check("t1_oreq_valid", 128'(bus.oreq.valid), 128'(1));
    beats(0, 16, s);
    bus.ireqs[0] = '0;
    check("t1_beats", 128'(s), 128'(16));
    check("t1_busy_drop", 128'(busy), 128'(0));
    check("t1_len_err", 128'(len_err), 128'(0));

    // 2/3: simultaneous requests after reset.
    do_reset();
    r0 = '0;
    r0.valid = 1'b1;
    r0.addr  = 32'h0000_2000;
    r0.size  = MSIZE8;
    r0.len   = MLEN4;
    r1 = r0;
    r1.addr  = 32'h0000_3000;
    bus.ireqs[0] = r0;
    bus.ireqs[1] = r1;
    wait_grant(w);
    check("t2_first_lat", 128'(w), 128'(1));
    check("t2_first_addr", 128'(bus.oreq.addr), 128'(32'h0000_2000));
    beats(0, 4, s);
    check("t2_first_beats", 128'(s), 128'(4));
    check("t2_idle_gap", 128'(busy), 128'(0));
`ifdef CBUS_ARB_FIXED_PRIO_EN
    second = 0;
`else
    second = 1;
`endif
    wait_grant(w);
    check("t2_second_lat", 128'(w), 128'(1));
    check("t2_second_addr", 128'(bus.oreq.addr),
          (second == 0) ? 128'(32'h0000_2000) : 128'(32'h0000_3000));
    beats(second, 4, s);
    check("t2_second_beats", 128'(s), 128'(4));
    wait_grant(w);
    check("t2_third_addr", 128'(bus.oreq.addr), 128'(32'h0000_2000));
    beats(0, 4, s);
    bus.ireqs[0] = '0;
    bus.ireqs[1] = '0;
    check("t2_third_beats", 128'(s), 128'(4));

    // 4: single-beat uncached write on input 1.
    @(negedge clk);
    r1 = '0;
    r1.valid    = 1'b1;
    r1.is_write = 1'b1;
    r1.addr     = 32'h1fc0_0010;
    r1.size     = MSIZE4;
    r1.strobe   = 8'h0f;
    r1.data     = 64'h0000_0000_cafe_f00d;
    r1.len      = MLEN1;
    bus.ireqs[1] = r1;
    wait_grant(w);
    check("t4_oreq_verbatim", 128'(bus.oreq), 128'(r1));
    bus.oresp.ready = 1'b1;
    bus.oresp.last  = 1'b1;
    bus.oresp.data  = 64'h1234_5678_9abc_def0;
    #1;
    check("t4_iresps0_zero", 128'(bus.iresps[0]), 128'(0));
    check("t4_iresps1_last", 128'(bus.iresps[1].last), 128'(1));
    check("t4_iresps1_data", 128'(bus.iresps[1].data), 128'(64'h1234_5678_9abc_def0));
    @(negedge clk);
    bus.oresp = '0;
    bus.ireqs[1] = '0;
    check("t4_busy_drop", 128'(busy), 128'(0));
    check("t4_len_err", 128'(len_err), 128'(0));

    // 5: short burst sets sticky len_err.
    r0 = '0;
    r0.valid = 1'b1;
    r0.addr  = 32'h0000_4000;
    r0.size  = MSIZE8;
    r0.len   = MLEN16;
    bus.ireqs[0] = r0;
    wait_grant(w);
    beats(0, 3, s);
    bus.ireqs[0] = '0;
    check("t5_short_beats", 128'(s), 128'(3));
    check("t5_len_err_set", 128'(len_err), 128'(1));
    r1 = '0;
    r1.valid = 1'b1;
    r1.addr  = 32'h0000_5000;
    r1.size  = MSIZE8;
    r1.len   = MLEN2;
    bus.ireqs[1] = r1;
    wait_grant(w);
    beats(1, 2, s);
    bus.ireqs[1] = '0;
    check("t5_len_err_sticky1", 128'(len_err), 128'(1));
    r0.len  = MLEN1;
    bus.ireqs[0] = r0;
    wait_grant(w);
    beats(0, 1, s);
    bus.ireqs[0] = '0;
    check("t5_len_err_sticky2", 128'(len_err), 128'(1));

    // 6: reset on beat 5 of a 16-beat burst.
    do_reset();
    check("t6_reset_clear", 128'(len_err), 128'(0));
    r0 = '0;
    r0.valid = 1'b1;
    r0.addr  = 32'h0000_6000;
    r0.size  = MSIZE8;
    r0.len   = MLEN16;
    bus.ireqs[0] = r0;
    wait_grant(w);
    beats(0, 4, s);
    bus.oresp.ready = 1'b1;
    bus.oresp.data  = 64'h5;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("t6_oreq_zero", 128'(bus.oreq), 128'(0));
    check("t6_busy_zero", 128'(busy), 128'(0));
    check("t6_iresps0_zero", 128'(bus.iresps[0]), 128'(0));
    check("t6_iresps1_zero", 128'(bus.iresps[1]), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    r1 = '0;
    r1.valid = 1'b1;
    r1.addr  = 32'h0000_7000;
    r1.size  = MSIZE8;
    r1.len   = MLEN4;
    bus.ireqs[1] = r1;
    wait_grant(w);
    check("t6_regrant_lat", 128'(w), 128'(1));
    check("t6_regrant_addr", 128'(bus.oreq.addr), 128'(32'h0000_7000));
    beats(1, 4, s);
    bus.ireqs[1] = '0;
    check("t6_regrant_beats", 128'(s), 128'(4));
    check("t6_len_err_clean", 128'(len_err), 128'(0));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
